// File: rtl/iob_responder.sv
// iob_responder: 68000-style PDS/IOB bus responder with DTACK/VPA termination; define IOB_BERR_EN for the bus-error timeout
module iob_responder #(
  parameter int WAIT_CYC = 2,
  parameter int TO_CYC   = 255,
  parameter int SYNC_LEN = 2
) (
  input  logic C16M,
  input  logic RES,
  input  logic E,
  input  logic nAS_IOB,
  input  logic nUDS_IOB,
  input  logic nLDS_IOB,
  input  logic nWE_IOB,
  input  logic nVMA_IOB,
  input  logic SEL,
  input  logic VSEL,
  input  logic LRDY,
  output logic nDTACK_IOB,
  output logic nVPA_IOB,
  output logic nBERR_IOB,
  output logic LRD,
  output logic LWR,
  output logic LU,
  output logic LL,
  output logic DinOE
);
  typedef enum logic [2:0] {sIdle, sAcc, sWait, sAck, sVpa, sEnd, sBerr} stateT;
  stateT state;
  logic [SYNC_LEN-1:0] asSh, vmaSh;
  logic [SYNC_LEN:0] eSh;
  logic [3:0] waitCnt;
  logic vmaSeen, vpaDone, toHit, asS, vmaS, eFall, busy;
  assign asS = asSh[SYNC_LEN-1];
  assign vmaS = vmaSh[SYNC_LEN-1];
  assign eFall = eSh[SYNC_LEN] && !eSh[SYNC_LEN-1];
  assign busy = state == sAcc || state == sWait || state == sVpa;
  always_ff @(posedge C16M or posedge RES)
    if (RES) begin
      asSh <= '1;
      vmaSh <= '1;
      eSh <= '0;
    end else begin
      asSh <= {asSh[SYNC_LEN-2:0], nAS_IOB};
      vmaSh <= {vmaSh[SYNC_LEN-2:0], nVMA_IOB};
      eSh <= {eSh[SYNC_LEN-1:0], E};
    end
`ifdef IOB_BERR_EN
  logic [7:0] toCnt;
  always_ff @(posedge C16M or posedge RES)
    if (RES) toCnt <= '0;
    else toCnt <= busy ? toCnt + 8'd1 : 8'd0;
  assign toHit = busy && toCnt == 8'(TO_CYC - 1);
`else
  assign toHit = 1'b0 && (TO_CYC > 0);
`endif
  always_ff @(posedge C16M or posedge RES)
    if (RES) begin
      state <= sIdle;
      nDTACK_IOB <= 1'b1;
      nVPA_IOB <= 1'b1;
      nBERR_IOB <= 1'b1;
      LRD <= 1'b0;
      LWR <= 1'b0;
      LU <= 1'b0;
      LL <= 1'b0;
      DinOE <= 1'b0;
      waitCnt <= '0;
      vmaSeen <= 1'b0;
      vpaDone <= 1'b0;
    end else begin
      LRD <= 1'b0;
      LWR <= 1'b0;
      case (state)
        sIdle: if (!asS && (SEL || VSEL)) begin
          state <= SEL ? sAcc : sVpa;
          nVPA_IOB <= SEL;
          LRD <= SEL && nWE_IOB;
          LWR <= SEL && !nWE_IOB;
          LU <= SEL ? !nUDS_IOB : LU;
          LL <= SEL ? !nLDS_IOB : LL;
          DinOE <= nWE_IOB;
          vmaSeen <= 1'b0;
          vpaDone <= 1'b0;
        end
        sAcc, sWait, sVpa: if (asS) begin
          state <= (state == sVpa && vpaDone) ? sEnd : sIdle;
          nVPA_IOB <= 1'b1;
          DinOE <= 1'b0;
        end else if (toHit) begin
          state <= sBerr;
          nBERR_IOB <= 1'b0;
          nVPA_IOB <= 1'b1;
          DinOE <= 1'b0;
        end else if (state == sAcc) begin
          state <= sWait;
          waitCnt <= 4'(WAIT_CYC);
        end else if (state == sWait) begin
          waitCnt <= waitCnt - {3'b0, waitCnt != 4'd0};
          if (waitCnt == 4'd0 && LRDY) begin
            state <= sAck;
            nDTACK_IOB <= 1'b0;
          end
        end else begin
          // VMA only has to be seen once; the strobe waits for the next E fall
          vmaSeen <= vmaSeen || !vmaS;
          if (!vpaDone && (vmaSeen || !vmaS) && eFall) begin
            vpaDone <= 1'b1;
            LRD <= nWE_IOB;
            LWR <= !nWE_IOB;
            LU <= !nUDS_IOB;
            LL <= !nLDS_IOB;
          end
        end
        sAck, sBerr: if (asS) begin
          state <= sEnd;
          nDTACK_IOB <= 1'b1;
          nBERR_IOB <= 1'b1;
          DinOE <= 1'b0;
        end
        default: state <= sIdle;
      endcase
    end
endmodule
